inst_mem_loader: RTL and testbench

Write-side companion to the byte-addressed instruction memory. The block accepts 32-bit instruction words over a valid/ready stream, for example from a boot UART or testbench host. It splits each word into four bytes and writes them, one byte per cycle, to the memory's byte write port. Byte order is big-endian, matching the fetch path: bits [31:24] go to address A, and bits [7:0] go to address A+3. The block sits between the boot/debug source and the instruction memory, and runs before the core is released from reset.

---
 rtl/inst_mem_loader_pkg.sv | 13 +
 rtl/inst_mem_loader.sv | 145 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_mem_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2
   } loader_state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BEAT_W         = 2;

endpackage

// File: rtl/inst_mem_loader.sv
// Streams 32-bit words into a byte-wide memory port, big-endian, one byte per cycle.
// Optional running checksum port enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 2048,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [31:0]       word_data,
   input  logic              word_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow_err,
   output logic [15:0]       words_loaded
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   localparam int unsigned       EXT_W     = ADDR_W + 1;
   localparam logic [EXT_W-1:0]  MEM_LIMIT = EXT_W'(MEM_BYTES);
   localparam logic [EXT_W-1:0]  WORD_STEP = EXT_W'(BYTES_PER_WORD);
   localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [31:0]       shift_q;
   logic [BEAT_W-1:0] beat_q;
   logic              last_q;
   logic              done_q;
   logic              ovf_q;
   logic [15:0]       words_q;
   logic              word_fits;
   logic              last_beat;

   // Extra bit keeps the bound check correct even when the pointer is near 2^ADDR_W.
   assign word_fits = ({1'b0, ptr_q} + WORD_STEP) <= MEM_LIMIT;
   assign last_beat = (beat_q == '1);

   assign done         = done_q;
   assign overflow_err = ovf_q;
   assign words_loaded = words_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      word_ready = 1'b0;
      busy       = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            word_ready = 1'b1;
            busy       = 1'b1;
            if (word_valid) state_d = word_fits ? WRITE : IDLE;
         end
         WRITE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_wdata = shift_q[31:24];
            if (last_beat) state_d = last_q ? IDLE : LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] cks_q;
   assign checksum = cks_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cks_q <= '0;
      end else if (state_q == IDLE && start) begin
         cks_q <= '0;
      end else if (state_q == LOAD && word_valid && word_fits) begin
         cks_q <= cks_q + word_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= BASE_PTR;
         shift_q <= '0;
         beat_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         words_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ptr_q   <= BASE_PTR;
                  words_q <= '0;
                  done_q  <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            LOAD: begin
               if (word_valid) begin
                  if (word_fits) begin
                     shift_q <= word_data;
                     last_q  <= word_last;
                     beat_q  <= '0;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               shift_q <= {shift_q[23:0], 8'h00};
               ptr_q   <= ptr_q + ADDR_W'(1);
               beat_q  <= beat_q + BEAT_W'(1);
               if (last_beat) begin
                  if (words_q != '1) words_q <= words_q + 16'd1;
                  if (last_q) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: default-size and 8-byte instances share one stimulus stream.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        word_valid;
   logic        word_last;
   logic [31:0] word_data;

   logic        we   [2];
   logic [31:0] addr [2];
   logic [7:0]  wd   [2];
   logic        rdy  [2];
   logic        bsy  [2];
   logic        dn   [2];
   logic        ovf  [2];
   logic [15:0] wl   [2];
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] ck   [2];
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   inst_mem_loader #(.MEM_BYTES(2048)) dut_big (
      .clk(clk), .rst_n(rst_n), .start(start),
      .word_valid(word_valid), .word_ready(rdy[0]), .word_data(word_data), .word_last(word_last),
      .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd[0]),
      .busy(bsy[0]), .done(dn[0]), .overflow_err(ovf[0]), .words_loaded(wl[0])
`ifdef LOADER_CHECKSUM_EN
      , .checksum(ck[0])
`endif
   );

   inst_mem_loader #(.MEM_BYTES(8)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(start),
      .word_valid(word_valid), .word_ready(rdy[1]), .word_data(word_data), .word_last(word_last),
      .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wd[1]),
      .busy(bsy[1]), .done(dn[1]), .overflow_err(ovf[1]), .words_loaded(wl[1])
`ifdef LOADER_CHECKSUM_EN
      , .checksum(ck[1])
`endif
   );

   function automatic void chk(input string nm, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %h want %h", nm, inst, $time, act, exp);
      end
   endfunction

   function automatic int mem_bytes(input int i);
      return (i == 0) ? 2048 : 8;
   endfunction

   // Model: a session is active between start and completion; each accepted word
   // becomes four pending bytes drained one per cycle; ready only when nothing pending.
   bit          m_act   [2];
   int          m_pend  [2];
   logic [31:0] m_word  [2];
   logic [31:0] m_pa    [2];
   logic [31:0] m_ptr   [2];
   logic [31:0] m_cks   [2];
   bit          m_lastp [2];
   bit          m_done  [2];
   bit          m_ovf   [2];
   int          m_words [2];

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_act[i] = 0; m_pend[i] = 0; m_word[i] = '0; m_pa[i] = '0; m_ptr[i] = '0;
            m_cks[i] = '0; m_lastp[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_words[i] = 0;
         end else if (!m_act[i]) begin
            if (start) begin
               m_act[i] = 1; m_ptr[i] = '0; m_words[i] = 0;
               m_done[i] = 0; m_ovf[i] = 0; m_cks[i] = '0;
            end
         end else if (m_pend[i] > 0) begin
            m_pend[i]--;
            m_word[i] = m_word[i] << 8;
            m_pa[i]++;
            if (m_pend[i] == 0) begin
               if (m_words[i] < 65535) m_words[i]++;
               if (m_lastp[i]) begin m_done[i] = 1; m_act[i] = 0; end
            end
         end else if (word_valid) begin
            if (m_ptr[i] + 4 <= mem_bytes(i)) begin
               m_pend[i]  = 4;
               m_word[i]  = word_data;
               m_pa[i]    = m_ptr[i];
               m_ptr[i]   = m_ptr[i] + 4;
               m_lastp[i] = word_last;
               m_cks[i]   = m_cks[i] + word_data;
            end else begin
               m_ovf[i] = 1; m_act[i] = 0;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("mem_we", i, we[i], m_pend[i] > 0);
         if (m_pend[i] > 0) begin
            chk("mem_addr", i, addr[i], m_pa[i]);
            chk("mem_wdata", i, wd[i], m_word[i][31:24]);
         end
         chk("word_ready", i, rdy[i], m_act[i] && m_pend[i] == 0);
         chk("busy", i, bsy[i], m_act[i]);
         chk("done", i, dn[i], m_done[i]);
         chk("overflow_err", i, ovf[i], m_ovf[i]);
         chk("words_loaded", i, wl[i], m_words[i]);
`ifdef LOADER_CHECKSUM_EN
         chk("checksum", i, ck[i], m_cks[i]);
`endif
      end
   end

   logic [31:0] log_a [$];
   logic [7:0]  log_d [$];
   int          log_t [$];
   int cyc = 0, n_small_wr = 0, n_small_hi = 0, n_rst_wr = 0, n_busy = 0;
   bit busy_en = 0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
         if (we[0]) begin log_a.push_back(addr[0]); log_d.push_back(wd[0]); log_t.push_back(cyc); end
         if (we[1]) begin n_small_wr++; if (addr[1] >= 8) n_small_hi++; end
      end else if (we[0] || we[1]) begin
         n_rst_wr++;
      end
      if (busy_en && bsy[0]) n_busy++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      logic r;
      word_valid = 1'b1; word_data = d; word_last = l;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         r = rdy[0];
         tick();
         if (r) return;
      end
      n_cmp++; n_fail++;
      $display("FAIL send_word timeout: got no ready want ready");
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100; k++) begin
         if (!m_act[0] && !m_act[1]) return;
         tick();
      end
      n_cmp++; n_fail++;
      $display("FAIL wait_idle timeout: got busy want idle");
   endtask

   logic [7:0] exp1 [4] = '{8'hE3, 8'hA0, 8'h10, 8'h05};

   initial begin
      rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_data = '0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(); tick();

      // Single word
      log_a.delete(); log_d.delete(); log_t.delete();
      pulse_start();
      send_word(32'hE3A01005, 1'b1);
      word_valid = 1'b0;
      wait_idle();
      tick();
      chk("s1_nwr", 0, log_a.size(), 4);
      for (int k = 0; k < 4 && k < log_a.size(); k++) begin
         chk("s1_addr", 0, log_a[k], k);
         chk("s1_data", 0, log_d[k], exp1[k]);
         chk("s1_cycle", 0, log_t[k] - log_t[0], k);
      end
      chk("s1_done", 0, dn[0], 1);
      chk("s1_words", 0, wl[0], 1);

      // Stream of three, valid held; small instance overflows on the third
      log_a.delete(); log_d.delete(); log_t.delete();
      n_small_wr = 0; n_small_hi = 0; n_busy = 0;
      busy_en = 1;
      pulse_start();
      send_word(32'h01020304, 1'b0);
      send_word(32'h05060708, 1'b0);
      send_word(32'h090A0B0C, 1'b1);
      word_valid = 1'b0;
      wait_idle();
      tick();
      busy_en = 0;
      chk("s2_nwr", 0, log_a.size(), 12);
      for (int k = 0; k < 12 && k < log_a.size(); k++) begin
         chk("s2_addr", 0, log_a[k], k);
         chk("s2_data", 0, log_d[k], k + 1);
      end
      chk("s2_busy_cycles", 0, n_busy, 15);
      chk("s2_words", 0, wl[0], 3);
      chk("s2_done", 0, dn[0], 1);
      chk("s2_small_nwr", 1, n_small_wr, 8);
      chk("s2_small_hi", 1, n_small_hi, 0);
      chk("s2_small_ovf", 1, ovf[1], 1);
      chk("s2_small_done", 1, dn[1], 0);
      chk("s2_small_words", 1, wl[1], 2);

      // Restart, start while busy, then reset mid-write
      pulse_start();
      chk("s3_cleared_words", 1, wl[1], 0);
      chk("s3_cleared_ovf", 1, ovf[1], 0);
      send_word(32'hCAFEBABE, 1'b0);
      word_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word(32'h11223344, 1'b1);
      word_valid = 1'b0;
      chk("s3_words", 0, wl[0], 1);
      tick(); tick();
      chk("s3_addr_beat2", 0, addr[0], 6);
      chk("s3_data_beat2", 0, wd[0], 8'h33);
      n_rst_wr = 0;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_we", i, we[i], 0);
         chk("rst_addr", i, addr[i], 0);
         chk("rst_wdata", i, wd[i], 0);
         chk("rst_ready", i, rdy[i], 0);
         chk("rst_busy", i, bsy[i], 0);
         chk("rst_done", i, dn[i], 0);
         chk("rst_ovf", i, ovf[i], 0);
         chk("rst_words", i, wl[i], 0);
      end
      tick(); tick(); tick();
      chk("rst_no_writes", 0, n_rst_wr, 0);
      rst_n = 1'b1;
      tick(); tick(); tick();

      // Checksum wrap
      pulse_start();
      send_word(32'hFFFFFFFF, 1'b0);
      send_word(32'h00000002, 1'b1);
      word_valid = 1'b0;
      wait_idle();
      tick();
      chk("s4_done", 0, dn[0], 1);
      chk("s4_words", 0, wl[0], 2);
      chk("s4_small_done", 1, dn[1], 1);
`ifdef LOADER_CHECKSUM_EN
      chk("s4_checksum", 0, ck[0], 32'h00000001);
      chk("s4_checksum", 1, ck[1], 32'h00000001);
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
